// File: rtl/ms_counter_pkg.sv
`timescale 1ms/100us
// Shared defaults and elaboration helpers for the elapsed-time meter.
// Pure constants and constant functions; no logic.
package ms_counter_pkg;

  localparam int BITS_DEF        = 10;
  localparam int MS_PER_TICK_DEF = 2;
  localparam int MS_W_DEF        = 11;

  // Minimum ms width that can hold the largest count times the tick period.
  function automatic int ms_width(input int bits, input int mpt);
    longint max_v;
    max_v = ((longint'(1) << bits) - 1) * longint'(mpt);
    return $clog2(max_v + 1);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ms_counter_if.sv
`timescale 1ms/100us
// Control and result bundle of the elapsed-time meter.
// The master drives Enable/latch; the slave (meter) returns count/ms.
interface ms_counter_if
  import ms_counter_pkg::*;
#(
  parameter int BITS = BITS_DEF,
  parameter int MS_W = MS_W_DEF
);

  logic            Enable;
  logic            latch;
  logic [BITS-1:0] count;
  logic [MS_W-1:0] ms;

  modport master (output Enable, output latch, input count, input ms);
  modport slave  (input Enable, input latch, output count, output ms);

endinterface

// File: rtl/ms_counter_tick_counter.sv
`timescale 1ms/100us
// Falling-edge tick counter with enable and async active-low clear; wraps at 2^BITS.
// count is registered; count_next is the combinational value it takes on the next edge.
module tick_counter
  import ms_counter_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic            NEclk,
  input  logic            Nreset,
  input  logic            i_en,
  output logic [BITS-1:0] o_count,
  output logic [BITS-1:0] o_count_next
);

  localparam logic [BITS-1:0] ONE = BITS'(1);

  logic [BITS-1:0] r_count;
  logic [BITS-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (i_en) begin
      w_count_next = r_count + ONE;
    end
  end

  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count      = r_count;
  assign o_count_next = w_count_next;

endmodule

// File: rtl/ms_counter.sv
`timescale 1ms/100us
// Elapsed-time meter: tick counter plus registered count->ms conversion with hold.
// ms is computed from the next count so it matches count in the same cycle; latch freezes ms only.
module ms_counter
  import ms_counter_pkg::*;
#(
  parameter int BITS        = BITS_DEF,
  parameter int MS_PER_TICK = MS_PER_TICK_DEF,
  parameter int MS_W        = MS_W_DEF
) (
  input  logic         NEclk,
  input  logic         Nreset,
  ms_counter_if.slave  bus
);

  localparam int SHIFT = $clog2(MS_PER_TICK);

  if (MS_PER_TICK < 1) begin : g_bad_mpt
    $error("ms_counter: MS_PER_TICK must be at least 1");
  end

  if (MS_W < ms_width(BITS, MS_PER_TICK)) begin : g_bad_ms_w
    $error("ms_counter: MS_W too narrow for BITS and MS_PER_TICK");
  end

  logic [BITS-1:0] w_count;
  logic [BITS-1:0] w_count_next;
  logic [MS_W-1:0] w_ms_conv;
  logic [MS_W-1:0] r_ms;

  tick_counter #(
    .BITS (BITS)
  ) u_tick (
    .NEclk        (NEclk),
    .Nreset       (Nreset),
    .i_en         (bus.Enable),
    .o_count      (w_count),
    .o_count_next (w_count_next)
  );

  // MS_W is never narrower than BITS, so the cast only zero-extends.
  if (is_pow2(MS_PER_TICK)) begin : g_shift
    assign w_ms_conv = MS_W'(w_count_next) << SHIFT;
  end else begin : g_mult
    assign w_ms_conv = MS_W'(w_count_next) * MS_W'(MS_PER_TICK);
  end

  always_ff @(negedge NEclk or negedge Nreset) begin
    if (!Nreset) begin
      r_ms <= '0;
    end else if (!bus.latch) begin
      r_ms <= w_ms_conv;
    end
  end

  assign bus.count = w_count;
  assign bus.ms    = r_ms;

endmodule

// File: tb/tb_ms_counter.sv
`timescale 1ms/100us
// Directed bench for ms_counter with a tick-level reference model checked every cycle.
module tb_ms_counter;

  localparam int BITS = 10;
  localparam int MPT  = 2;
  localparam int MS_W = 11;
  localparam int CNT_MOD = 1 << BITS;
  localparam int MS_MOD  = 1 << MS_W;

  logic NEclk  = 1'b1;
  logic Nreset = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  int m_cnt = 0;
  int m_ms  = 0;

  ms_counter_if #(.BITS(BITS), .MS_W(MS_W)) u_if ();

  ms_counter #(
    .BITS        (BITS),
    .MS_PER_TICK (MPT),
    .MS_W        (MS_W)
  ) dut (
    .NEclk  (NEclk),
    .Nreset (Nreset),
    .bus    (u_if)
  );

  always #1 NEclk = ~NEclk;

  // Reference: elapsed ticks modulo 2^BITS; ms is ticks*period unless frozen.
  always @(negedge NEclk or negedge Nreset) begin
    int nc;
    if (!Nreset) begin
      m_cnt <= 0;
      m_ms  <= 0;
    end else begin
      nc = u_if.Enable ? (m_cnt + 1) % CNT_MOD : m_cnt;
      m_cnt <= nc;
      if (!u_if.latch) begin
        m_ms <= (nc * MPT) % MS_MOD;
      end
    end
  end

  // Outputs move on falling edges; compare on every rising edge.
  always @(posedge NEclk) begin
    n_checks++;
    if (int'(u_if.count) != m_cnt) begin
      n_errors++;
      $display("FAIL model_count t=%0t actual=%0d required=%0d", $time, u_if.count, m_cnt);
    end
    n_checks++;
    if (int'(u_if.ms) != m_ms) begin
      n_errors++;
      $display("FAIL model_ms t=%0t actual=%0d required=%0d", $time, u_if.ms, m_ms);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_pair(input string name, input int exp_cnt, input int exp_ms);
    chk({name, "_count"}, int'(u_if.count), exp_cnt);
    chk({name, "_ms"}, int'(u_if.ms), exp_ms);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge NEclk);
  endtask

  initial begin
    $monitor("t=%0t Nreset=%b Enable=%b latch=%b count=%0d ms=%0d",
             $time, Nreset, u_if.Enable, u_if.latch, u_if.count, u_if.ms);
    u_if.Enable = 1'b0;
    u_if.latch  = 1'b0;
    Nreset      = 1'b0;

    // 1) reset, then five enabled edges
    #0.5;
    chk_pair("reset", 0, 0);
    @(posedge NEclk);
    Nreset      = 1'b1;
    u_if.Enable = 1'b1;
    step(5);
    chk_pair("five_edges", 5, 10);

    // 2) async reset at count 7, counting resumes from 1
    step(2);
    chk_pair("pre_reset", 7, 14);
    #0.5 Nreset = 1'b0;
    #0.1;
    chk_pair("async_clear", 0, 0);
    #3.9 Nreset = 1'b1;
    @(posedge NEclk);
    chk_pair("resume", 1, 2);

    // 3) enable hold at 3
    step(2);
    u_if.Enable = 1'b0;
    step(2);
    chk_pair("en_hold", 3, 6);
    u_if.Enable = 1'b1;
    step(1);
    chk_pair("en_resume", 4, 8);

    // 4) full range from reset and wrap
    #0.3 Nreset = 1'b0;
    #0.3 Nreset = 1'b1;
    step(1023);
    chk_pair("full_scale", 1023, 2046);
    step(1);
    chk_pair("wrap", 0, 0);

    // 5) latch holds ms, release resynchronises
    step(10);
    chk_pair("pre_latch", 10, 20);
    u_if.latch = 1'b1;
    step(5);
    chk_pair("latched", 15, 20);
    u_if.latch = 1'b0;
    step(1);
    chk_pair("unlatch", 16, 32);

    // 6) reset while latched
    u_if.latch = 1'b1;
    step(2);
    chk_pair("latch_again", 18, 32);
    #0.5 Nreset = 1'b0;
    #0.1;
    chk_pair("latch_reset", 0, 0);
    #0.2 Nreset = 1'b1;
    step(3);
    chk_pair("latch_after_rst", 3, 0);
    u_if.latch = 1'b0;
    step(1);
    chk_pair("latch_release", 4, 8);

    // Enable=0 with latch=0 stays stable; enable glitch between edges ignored
    u_if.Enable = 1'b0;
    step(2);
    chk_pair("idle", 4, 8);
    #0.3 u_if.Enable = 1'b1;
    #0.3 u_if.Enable = 1'b0;
    @(posedge NEclk);
    chk_pair("glitch", 4, 8);
    u_if.Enable = 1'b1;
    step(3);
    chk_pair("final", 7, 14);

    $monitoroff;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
